// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: counts rising spike edges over back-to-back windows and
// measures the inter-spike interval between the two most recent edges.
module spike_rate_decoder #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spike,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic [CNT_W-1:0] isi,
    output logic             isi_valid,
    output logic             overrun
);

    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state, w_state_nxt;
    logic             r_spike_q;
    logic [WIN_W-1:0] r_win_cnt, w_win_nxt;
    logic [CNT_W-1:0] r_spike_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_rate, r_isi, r_isi_timer;
    logic             r_rate_valid, r_isi_valid, r_overrun, r_isi_armed;

    logic             w_edge, w_done;
    logic [WIN_W-1:0] w_win_load;
    logic [CNT_W-1:0] w_cnt_edge;

    assign w_edge     = spike & ~r_spike_q;
    assign w_win_load = (window_len == '0) ? WIN_W'(1) : window_len;
    // Count including this cycle's edge, saturating.
    assign w_cnt_edge = (w_edge && r_spike_cnt != CNT_MAX) ? r_spike_cnt + CNT_W'(1)
                                                           : r_spike_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_win_nxt   = r_win_cnt;
        w_cnt_nxt   = r_spike_cnt;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_win_nxt   = w_win_load;
                    w_cnt_nxt   = '0;
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (r_win_cnt == WIN_W'(1)) begin
                    // Final cycle always completes; enable only picks restart vs idle.
                    w_done    = 1'b1;
                    w_cnt_nxt = '0;
                    if (enable) begin
                        w_win_nxt = w_win_load;
                    end else begin
                        w_win_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end else if (!enable) begin
                    w_win_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_win_nxt = r_win_cnt - WIN_W'(1);
                    w_cnt_nxt = w_cnt_edge;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_spike_q    <= 1'b0;
            r_win_cnt    <= '0;
            r_spike_cnt  <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_spike_q   <= spike;
            r_win_cnt   <= w_win_nxt;
            r_spike_cnt <= w_cnt_nxt;
            if (w_done) begin
                r_rate       <= w_cnt_edge;
                r_rate_valid <= 1'b1;
                if (r_rate_valid && !rate_ready) r_overrun <= 1'b1;
            end else if (r_rate_valid && rate_ready) begin
                r_rate_valid <= 1'b0;
            end
        end
    end

    // ISI runs independently of the window FSM; the first edge only arms it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_isi_timer <= '0;
            r_isi       <= '0;
            r_isi_valid <= 1'b0;
            r_isi_armed <= 1'b0;
        end else if (w_edge) begin
            r_isi_armed <= 1'b1;
            r_isi_timer <= CNT_W'(1);
            if (r_isi_armed) begin
                r_isi       <= r_isi_timer;
                r_isi_valid <= 1'b1;
            end
        end else if (r_isi_armed && r_isi_timer != CNT_MAX) begin
            r_isi_timer <= r_isi_timer + CNT_W'(1);
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign isi        = r_isi;
    assign isi_valid  = r_isi_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: windowed rate, handshake/overrun,
// ISI measurement, abort and reset behaviour.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spike;
    logic       enable;
    logic [7:0] window_len;
    logic [7:0] rate;
    logic       rate_valid;
    logic       rate_ready;
    logic [7:0] isi;
    logic       isi_valid;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    spike_rate_decoder #(.WIN_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spike      (spike),
        .enable     (enable),
        .window_len (window_len),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .isi        (isi),
        .isi_valid  (isi_valid),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rate"},       32'(rate),       32'd0);
        chk({tag, "_rate_valid"}, 32'(rate_valid), 32'd0);
        chk({tag, "_isi"},        32'(isi),        32'd0);
        chk({tag, "_isi_valid"},  32'(isi_valid),  32'd0);
        chk({tag, "_overrun"},    32'(overrun),    32'd0);
    endtask

    initial begin
        reset_n = 1'b0; spike = 1'b0; enable = 1'b0; window_len = 8'd0; rate_ready = 1'b0;
        #12;
        chk_all_zero("reset");
        cyc();
        reset_n = 1'b1;

        // Window of 10, edges at cycles 2, 5, 10.
        rate_ready = 1'b1; window_len = 8'd10; enable = 1'b1;
        cyc();
        for (int k = 1; k <= 10; k++) begin
            spike = (k == 2 || k == 5 || k == 10);
            cyc();
            if (k == 2) chk("a_isi_first", 32'(isi_valid), 32'd0);
            if (k == 5) begin
                chk("a_isi", 32'(isi), 32'd3);
                chk("a_isi_valid", 32'(isi_valid), 32'd1);
            end
            if (k == 9) chk("a_valid_early", 32'(rate_valid), 32'd0);
        end
        enable = 1'b0; spike = 1'b0;
        chk("a_rate", 32'(rate), 32'd3);
        chk("a_valid", 32'(rate_valid), 32'd1);
        cyc();
        chk("a_valid_clr", 32'(rate_valid), 32'd0);
        chk("a_rate_hold", 32'(rate), 32'd3);

        // Spike held 6 cycles in a window of 20 counts once.
        window_len = 8'd20; enable = 1'b1;
        cyc();
        for (int k = 1; k <= 20; k++) begin
            spike = (k >= 3 && k <= 8);
            cyc();
        end
        enable = 1'b0; spike = 1'b0;
        chk("b_rate", 32'(rate), 32'd1);
        chk("b_valid", 32'(rate_valid), 32'd1);
        cyc();
        chk("b_valid_clr", 32'(rate_valid), 32'd0);

        // Completion coinciding with an accepting handshake: no overrun.
        rate_ready = 1'b0; window_len = 8'd4; enable = 1'b1;
        cyc();
        for (int k = 1; k <= 8; k++) begin
            spike = (k == 2 || k == 5 || k == 7);
            rate_ready = (k == 8);
            cyc();
            if (k == 4) begin
                chk("d_rate1", 32'(rate), 32'd1);
                chk("d_valid1", 32'(rate_valid), 32'd1);
            end
        end
        chk("d_rate2", 32'(rate), 32'd2);
        chk("d_valid2", 32'(rate_valid), 32'd1);
        chk("d_overrun", 32'(overrun), 32'd0);
        enable = 1'b0; spike = 1'b0; rate_ready = 1'b1;
        cyc();
        chk("d_valid_clr", 32'(rate_valid), 32'd0);
        chk("d_rate_hold", 32'(rate), 32'd2);
        chk("d_overrun2", 32'(overrun), 32'd0);

        // Two windows of 8 without acceptance: overwrite and overrun.
        rate_ready = 1'b0; window_len = 8'd8; enable = 1'b1;
        cyc();
        for (int k = 1; k <= 16; k++) begin
            spike = (k == 3 || k == 10 || k == 13);
            cyc();
            if (k == 8) begin
                chk("c_rate1", 32'(rate), 32'd1);
                chk("c_valid1", 32'(rate_valid), 32'd1);
                chk("c_overrun1", 32'(overrun), 32'd0);
            end
            if (k == 12) chk("c_rate_stable", 32'(rate), 32'd1);
        end
        chk("c_rate2", 32'(rate), 32'd2);
        chk("c_valid2", 32'(rate_valid), 32'd1);
        chk("c_overrun2", 32'(overrun), 32'd1);
        enable = 1'b0; spike = 1'b0; rate_ready = 1'b1;
        cyc();
        chk("c_valid_clr", 32'(rate_valid), 32'd0);
        chk("c_overrun_sticky", 32'(overrun), 32'd1);
        chk("c_rate_hold", 32'(rate), 32'd2);

        // Window of 4, spike toggling each cycle: 2 edges per window.
        window_len = 8'd4; enable = 1'b1; spike = 1'b0;
        cyc();
        for (int k = 1; k <= 300; k++) begin
            spike = k[0];
            cyc();
            if (k % 4 == 0) begin
                chk("e_rate", 32'(rate), 32'd2);
                chk("e_valid", 32'(rate_valid), 32'd1);
            end
            if (k % 4 == 1 && k > 1) chk("e_valid_clr", 32'(rate_valid), 32'd0);
        end
        enable = 1'b0; spike = 1'b0;
        cyc();
        // window_len=0 gives 1-cycle windows.
        window_len = 8'd0; enable = 1'b1;
        cyc();
        for (int k = 1; k <= 6; k++) begin
            spike = k[0];
            cyc();
            chk("e0_rate", 32'(rate), 32'(k[0]));
            chk("e0_valid", 32'(rate_valid), 32'd1);
        end
        enable = 1'b0; spike = 1'b0;
        cyc();
        cyc();

        // Reset clears everything including sticky overrun, then ISI test.
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst2");
        cyc();
        reset_n = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            spike = (c == 10 || c == 17 || c == 400);
            cyc();
            if (c == 10) chk("f_no_isi_first", 32'(isi_valid), 32'd0);
            if (c == 16) chk("f_no_isi_before", 32'(isi_valid), 32'd0);
            if (c == 17) begin
                chk("f_isi7", 32'(isi), 32'd7);
                chk("f_isi7_valid", 32'(isi_valid), 32'd1);
            end
            if (c == 400) begin
                chk("f_isi_sat", 32'(isi), 32'd255);
                chk("f_isi_sat_valid", 32'(isi_valid), 32'd1);
            end
        end
        spike = 1'b0;

        // Abort at window cycle 5 leaves outputs untouched.
        window_len = 8'd10; enable = 1'b1; rate_ready = 1'b0;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            spike = (k == 1 || k == 3);
            cyc();
        end
        spike = 1'b0; enable = 1'b0;
        cyc();
        cyc(); cyc(); cyc();
        chk("g_rate", 32'(rate), 32'd0);
        chk("g_valid", 32'(rate_valid), 32'd0);
        chk("g_overrun", 32'(overrun), 32'd0);

        // Reset mid-window discards it.
        enable = 1'b1;
        cyc();
        for (int k = 1; k <= 4; k++) begin
            spike = (k == 2);
            cyc();
        end
        reset_n = 1'b0;
        #1;
        chk_all_zero("g_rst");
        cyc();
        reset_n = 1'b1; enable = 1'b0; spike = 1'b0;
        for (int k = 1; k <= 12; k++) cyc();
        chk("g_post_valid", 32'(rate_valid), 32'd0);
        chk("g_post_rate", 32'(rate), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL provide parameter WIN_W, default 8, meaning width of the window-length input and window counter.
REQ-002 SHALL provide parameter CNT_W, default 8, meaning width of the spike count, ISI and output registers.
REQ-003 SHALL provide port clk  input  1  meaning single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset_n  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL provide port spike  input  1  meaning neuron spike level, synchronous to clk, may stay high for multiple cycles.
REQ-006 SHALL provide port enable  input  1  meaning run continuous counting windows while high.
REQ-007 SHALL provide port window_len  input  WIN_W  meaning window length in cycles, sampled at window start.
REQ-008 SHALL provide port rate  output  CNT_W  meaning spike count of the last completed window.
REQ-009 SHALL provide port rate_valid  output  1  meaning rate holds an unconsumed result.
REQ-010 SHALL provide port rate_ready  input  1  meaning consumer accepts rate this cycle.
REQ-011 SHALL provide port isi  output  CNT_W  meaning cycles between the two most recent rising edges.
REQ-012 SHALL provide port isi_valid  output  1  meaning isi holds at least one measured interval.
REQ-013 SHALL provide port overrun  output  1  meaning sticky flag: a result was overwritten before acceptance.

Function
REQ-014 SHALL register spike into spike_q every cycle; edge = spike AND NOT spike_q; only edges are counted.
REQ-015 SHALL implement states IDLE and COUNT.
REQ-016 IDLE: enable=1 SHALL load win_cnt from window_len (0 treated as 1), clear spike_cnt, and enter COUNT next cycle.
REQ-017 COUNT: win_cnt SHALL decrement each cycle; each edge SHALL increment spike_cnt, saturating at 2^CNT_W-1.
REQ-018 The last window cycle is the one with win_cnt=1; an edge on that cycle SHALL be included in the result.
REQ-019 On the last cycle, rate SHALL load the final count and rate_valid SHALL be 1 on the next cycle.
REQ-020 On the last cycle with enable=1, the next window SHALL start with no gap: reload win_cnt, clear spike_cnt; otherwise go IDLE.
REQ-021 enable=0 during COUNT SHALL abort: discard the partial count, go IDLE next cycle, and leave rate/rate_valid unchanged.
REQ-022 Handshake: rate_valid AND rate_ready SHALL clear rate_valid next cycle; rate SHALL be stable while rate_valid=1 except under REQ-023.
REQ-023 A window completing while rate_valid=1 and rate_ready=0 SHALL overwrite rate, keep rate_valid=1 and set overrun.
REQ-024 A window completing in the same cycle as an accepting handshake SHALL load the new rate, keep rate_valid=1 and SHALL NOT set overrun.
REQ-025 isi_timer SHALL count cycles since the last edge, saturating at 2^CNT_W-1, and reset to 1 on the cycle after an edge.
REQ-026 On each edge after the first since reset, isi SHALL load isi_timer and isi_valid SHALL become 1; the first edge SHALL only arm the timer.
REQ-027 ISI measurement SHALL run regardless of enable/state.
REQ-028 Latency: edge-to-count is 1 cycle; last window cycle to rate_valid is 1 cycle.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE; spike_q, win_cnt, spike_cnt, isi_timer, rate, isi = 0; rate_valid, isi_valid, overrun = 0; ISI re-disarmed.
REQ-030 Reset asserted mid-window SHALL discard all partial state; no result is produced for that window.
REQ-031 overrun SHALL clear only on reset.

Verification
REQ-032 window_len=10, spike high for 1 cycle at window cycles 2, 5 and 10, rate_ready=1 -> rate=3, rate_valid pulses for 1 cycle.
REQ-033 spike held high for 6 cycles within one window of 20 -> rate=1.
REQ-034 window_len=4, continuous spike toggling every cycle for 300 cycles, CNT_W=8 -> rate=2 per window; with window_len=0 -> 1-cycle windows.
REQ-035 rate_ready=0, enable=1 for two windows of 8 -> second rate overwrites first, overrun=1, rate_valid=1; rate_ready=1 clears rate_valid, overrun stays 1.
REQ-036 Edges at cycles 10, 17, 400 -> isi=7 after the second edge; after the third edge isi=255 (saturated); no isi_valid after the first edge.
REQ-037 enable dropped at window cycle 5 of 10 after 2 edges, then reset pulsed during a later window -> no new rate; all outputs 0 after reset.
